// File: rtl/pipelined_alu_if.sv
// rtl/pipelined_alu_if.sv - operand/result handshake bundle for pipelined_alu
// Purpose: groups the input handshake, operands, result handshake and status
//          outputs of pipelined_alu into one interface.
// Ports (signals):
//   io_in_valid/io_in_ready    - operand/opcode handshake
//   io_a, io_b, io_opcode      - operands and operation select
//   io_out_valid/io_out_ready  - result handshake
//   io_out, io_carry, io_zero  - registered result and flags
//   io_acc, io_count           - accumulator value and accepted-transaction count
// Modports: master = requester side, slave = ALU side.
interface pipelined_alu_if #(
    parameter int W = 8
);
    logic           io_in_valid;
    logic           io_in_ready;
    logic [W-1:0]   io_a;
    logic [W-1:0]   io_b;
    logic [2:0]     io_opcode;
    logic           io_out_valid;
    logic           io_out_ready;
    logic [W-1:0]   io_out;
    logic           io_carry;
    logic           io_zero;
    logic [W-1:0]   io_acc;
    logic [15:0]    io_count;

    modport master (
        output io_in_valid, io_a, io_b, io_opcode, io_out_ready,
        input  io_in_ready, io_out_valid, io_out, io_carry, io_zero, io_acc, io_count
    );

    modport slave (
        input  io_in_valid, io_a, io_b, io_opcode, io_out_ready,
        output io_in_ready, io_out_valid, io_out, io_carry, io_zero, io_acc, io_count
    );
endinterface

// File: rtl/pipelined_alu.sv
// rtl/pipelined_alu.sv - single-stage ALU with valid/ready handshake and accumulator
// Purpose: accepts one operand/opcode transaction per cycle, returns the result,
//          carry and zero flags one cycle later from a single result register.
// Ports:
//   clk   - clock, all state on rising edge
//   reset - synchronous, active-high
//   bus   - pipelined_alu_if.slave (handshakes, operands, result, acc, count)
module pipelined_alu #(
    parameter int             W        = 8,
    parameter logic [W-1:0]   ACC_INIT = W'(8'hAB)
) (
    input  logic              clk,
    input  logic              reset,
    pipelined_alu_if.slave    bus
);
    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_PASA = 3'd2;
    localparam logic [2:0] OP_PASB = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_OR   = 3'd5;
    localparam logic [2:0] OP_XOR  = 3'd6;
    localparam logic [2:0] OP_ACC  = 3'd7;

    logic           r_out_valid;
    logic [W-1:0]   r_out;
    logic           r_carry;
    logic           r_zero;
    logic [W-1:0]   r_acc;
    logic [15:0]    r_count;

    logic           w_in_ready;
    logic           w_accept;
    logic           w_fire;
    logic [W:0]     w_sum;
    logic [W:0]     w_diff;
    logic [W:0]     w_acc_sum;
    logic [W-1:0]   w_result;
    logic           w_carry;

    // One result register, no skid: a new transaction can enter only when the
    // register is empty or is being drained in this same cycle.
    assign w_in_ready = !r_out_valid || bus.io_out_ready;
    assign w_accept   = bus.io_in_valid && w_in_ready;
    assign w_fire     = r_out_valid && bus.io_out_ready;

    // Widened by one bit so bit W is the carry (ADD/ACC) or the borrow (SUB).
    assign w_sum     = {1'b0, bus.io_a} + {1'b0, bus.io_b};
    assign w_diff    = {1'b0, bus.io_a} - {1'b0, bus.io_b};
    assign w_acc_sum = {1'b0, r_acc}    + {1'b0, bus.io_a};

    always_comb begin
        w_result = '0;
        w_carry  = 1'b0;
        case (bus.io_opcode)
            OP_ADD:  begin w_result = w_sum[W-1:0];     w_carry = w_sum[W];     end
            OP_SUB:  begin w_result = w_diff[W-1:0];    w_carry = w_diff[W];    end
            OP_PASA: w_result = bus.io_a;
            OP_PASB: w_result = bus.io_b;
            OP_AND:  w_result = bus.io_a & bus.io_b;
            OP_OR:   w_result = bus.io_a | bus.io_b;
            OP_XOR:  w_result = bus.io_a ^ bus.io_b;
            OP_ACC:  begin w_result = w_acc_sum[W-1:0]; w_carry = w_acc_sum[W]; end
            default: begin w_result = '0;               w_carry = 1'b0;         end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_carry     <= 1'b0;
            r_zero      <= 1'b0;
            r_acc       <= ACC_INIT;
            r_count     <= 16'h0000;
        end else if (w_accept) begin
            // Covers simultaneous fire too: valid stays high with the new result.
            r_out_valid <= 1'b1;
            r_out       <= w_result;
            r_carry     <= w_carry;
            r_zero      <= (w_result == '0);
            r_count     <= r_count + 16'd1;
            if (bus.io_opcode == OP_ACC) begin
                r_acc <= w_acc_sum[W-1:0];
            end
        end else if (w_fire) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.io_in_ready  = w_in_ready;
    assign bus.io_out_valid = r_out_valid;
    assign bus.io_out       = r_out;
    assign bus.io_carry     = r_carry;
    assign bus.io_zero      = r_zero;
    assign bus.io_acc       = r_acc;
    assign bus.io_count     = r_count;
endmodule
